vga_fb_ctrl: RTL

- Parametrised VGA display controller: programmable timing generator, scaled framebuffer with a byte-strobed bus write port, and a control register.
- Slave on the SoC data bus; decodes its own address region.
- Drives RGB888, hsync/vsync/valid and a per-frame vblank pulse.
- Successor to the fixed 640x480 controller: generalised timing, scaling, sync polarity and base decode; adds a write handshake, byte strobes, enable/blank control, range checking and frame status.

---
 rtl/vga_pkg.sv | 55 +++++
 rtl/vga_timing.sv | 74 +++++++
 rtl/vga_fb_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the VGA framebuffer controller.
// Holds the bus address field layout, control register bit positions,
// pixel layout and the functions that derive timing/framebuffer sizes
// from the module parameters.
package vga_pkg;

  // Control register bits
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_SWAP_BIT = 1;

  // Bus address fields
  localparam int REGION_HI    = 31;
  localparam int REGION_LO    = 28;
  localparam int CTRL_SEL_BIT = 27;
  localparam int IDX_HI       = 26;
  localparam int IDX_LO       = 2;
  localparam int IDX_W        = IDX_HI - IDX_LO + 1;

  // Pixel layout {R, G, B}, one byte lane per colour
  localparam int PIX_W  = 24;
  localparam int LANES  = 3;
  localparam int LANE_W = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Bits needed to hold values 0..n-1, never less than one bit
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int fb_w(input int h_active, input int shift);
    return h_active >> shift;
  endfunction

  function automatic int fb_h(input int v_active, input int shift);
    return v_active >> shift;
  endfunction

  function automatic int fb_aw(input int depth);
    return width_for(depth);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-tick divider, horizontal/vertical counters and the
// raw (unregistered, polarity-free) valid/sync/vblank indications that
// the top pipelines to the pins.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PCLK_DIV = 2,
  localparam int H_TOT   = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOT   = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW      = width_for(H_TOT),
  localparam int VW      = width_for(V_TOT)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          pix_en,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          valid_p0,
  output logic          hsync_act_p0,
  output logic          vsync_act_p0,
  output logic          vblank_p0
);

  localparam int DW       = width_for(PCLK_DIV);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [DW-1:0] div_cnt;
  logic          h_last;
  logic          v_last;

  assign pix_en = (div_cnt == DW'(PCLK_DIV - 1));
  assign h_last = (h_cnt == HW'(H_TOT - 1));
  assign v_last = (v_cnt == VW'(V_TOT - 1));

  // Clock divider producing one pixel tick every PCLK_DIV cycles
  always_ff @(posedge clk) begin
    if (!rst_n)      div_cnt <= '0;
    else if (pix_en) div_cnt <= '0;
    else             div_cnt <= div_cnt + 1'b1;
  end

  // Raster scan counters, advanced once per pixel tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign valid_p0     = (32'(h_cnt) < 32'(H_ACTIVE)) && (32'(v_cnt) < 32'(V_ACTIVE));
  assign hsync_act_p0 = (32'(h_cnt) >= 32'(HS_START)) && (32'(h_cnt) < 32'(HS_END));
  assign vsync_act_p0 = (32'(v_cnt) >= 32'(VS_START)) && (32'(v_cnt) < 32'(VS_END));
  // The tick on which the last visible line finishes
  assign vblank_p0    = pix_en && h_last && (v_cnt == VW'(V_ACTIVE - 1));

endmodule

// File: rtl/vga_fb_ctrl.sv
// vga_fb_ctrl: VGA display controller with a scaled, byte-strobed
// framebuffer written from the SoC bus and a small control register.
// Outputs are a two-stage pipeline behind the raster counters:
// stage 1 = framebuffer read + registered timing, stage 2 = pins.
// Optional build macro: VGA_DOUBLE_BUF_EN (front/back buffers swapped
// at vblank on request); without it a single buffer is used.
module vga_fb_ctrl
  import vga_pkg::*;
#(
  parameter int       H_ACTIVE    = 640,
  parameter int       H_FP        = 16,
  parameter int       H_SYNC      = 96,
  parameter int       H_BP        = 48,
  parameter int       V_ACTIVE    = 480,
  parameter int       V_FP        = 10,
  parameter int       V_SYNC      = 2,
  parameter int       V_BP        = 33,
  parameter int       PCLK_DIV    = 2,
  parameter int       SCALE_SHIFT = 1,
  parameter bit       SYNC_POL    = 1'b0,
  parameter bit [3:0] BASE_NIBBLE = 4'h5
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        WriteValid,
  input  logic [31:0] WriteAddrIn,
  input  logic [31:0] WriteDataIn,
  input  logic [3:0]  WriteStrb,
  output logic        SlaverWriteReady,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        valid,
  output logic        vblank_irq,
  output logic [15:0] frame_cnt,
  output logic        wr_err
);

  localparam int H_TOT  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW     = width_for(H_TOT);
  localparam int VW     = width_for(V_TOT);
  localparam int FB_W   = fb_w(H_ACTIVE, SCALE_SHIFT);
  localparam int FB_H   = fb_h(V_ACTIVE, SCALE_SHIFT);
  localparam int FB_PIX = FB_W * FB_H;
`ifdef VGA_DOUBLE_BUF_EN
  localparam int N_BUF  = 2;
`else
  localparam int N_BUF  = 1;
`endif
  localparam int FB_DEPTH = N_BUF * FB_PIX;
  localparam int MEM_AW   = fb_aw(FB_DEPTH);

  // Raster timing
  logic          pix_en;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          valid_p0;
  logic          hsync_act_p0;
  logic          vsync_act_p0;
  logic          vblank_p0;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .PCLK_DIV (PCLK_DIV)
  ) u_timing (
    .clk          (Clk),
    .rst_n        (Rst),
    .pix_en       (pix_en),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .valid_p0     (valid_p0),
    .hsync_act_p0 (hsync_act_p0),
    .vsync_act_p0 (vsync_act_p0),
    .vblank_p0    (vblank_p0)
  );

  // Bus decode
  logic             region_hit;
  logic             is_ctrl;
  logic [IDX_W-1:0] wr_idx;
  logic             idx_in_range;
  logic             pix_wr;
  logic             pix_drop;
  logic             ctrl_wr;
  logic             ctrl_en;
  logic [31:0]      rd_off;
  logic [31:0]      wr_off;
  logic [MEM_AW-1:0] rd_addr;
  logic [MEM_AW-1:0] wr_addr;
  logic             unused_bits;

  assign region_hit       = (WriteAddrIn[REGION_HI:REGION_LO] == BASE_NIBBLE);
  assign SlaverWriteReady = WriteValid && region_hit && Rst;
  assign is_ctrl          = WriteAddrIn[CTRL_SEL_BIT];
  assign wr_idx           = WriteAddrIn[IDX_HI:IDX_LO];
  assign idx_in_range     = (32'(wr_idx) < 32'(FB_PIX));
  assign pix_wr           = SlaverWriteReady && !is_ctrl && idx_in_range;
  assign pix_drop         = SlaverWriteReady && !is_ctrl && !idx_in_range;
  assign ctrl_wr          = SlaverWriteReady && is_ctrl && WriteStrb[0];
  assign unused_bits      = ^{WriteAddrIn[1:0], WriteStrb[3], WriteDataIn[31:24]};

  // Control register and sticky range error
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      ctrl_en <= 1'b1;
      wr_err  <= 1'b0;
    end else begin
      if (ctrl_wr)  ctrl_en <= WriteDataIn[CTRL_EN_BIT];
      if (pix_drop) wr_err  <= 1'b1;
    end
  end

  logic vblank_p1;

`ifdef VGA_DOUBLE_BUF_EN
  logic front_buf;
  logic swap_pend;

  // Buffer swap at vblank; a request landing on the swap cycle waits a frame
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      front_buf <= 1'b0;
      swap_pend <= 1'b0;
    end else begin
      if (vblank_p1 && swap_pend) front_buf <= ~front_buf;
      if (ctrl_wr && WriteDataIn[CTRL_SWAP_BIT]) swap_pend <= 1'b1;
      else if (vblank_p1)                        swap_pend <= 1'b0;
    end
  end

  assign rd_off = front_buf ? 32'(FB_PIX) : 32'd0;
  assign wr_off = front_buf ? 32'd0 : 32'(FB_PIX);
`else
  assign rd_off = 32'd0;
  assign wr_off = 32'd0;
`endif

  // Outside the visible area the read index is parked at the buffer base
  assign rd_addr = valid_p0
                 ? MEM_AW'(32'(v_cnt >> SCALE_SHIFT) * 32'(FB_W) + 32'(h_cnt >> SCALE_SHIFT) + rd_off)
                 : MEM_AW'(rd_off);
  assign wr_addr = MEM_AW'(32'(wr_idx) + wr_off);

  // ---- stage 0 -> stage 1 ----
  logic [PIX_W-1:0] fb_mem [FB_DEPTH];
  pixel_t           rd_data_p1;
  logic             vld_p1;
  logic             hs_p1;
  logic             vs_p1;

  // Framebuffer: byte-lane writes, read-before-write on the same index
  always_ff @(posedge Clk) begin
    if (pix_wr) begin
      for (int i = 0; i < LANES; i++) begin
        if (WriteStrb[i]) fb_mem[wr_addr][LANE_W*i +: LANE_W] <= WriteDataIn[LANE_W*i +: LANE_W];
      end
    end
    rd_data_p1 <= fb_mem[rd_addr];
  end

  // Timing indications aligned with the framebuffer read
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      vld_p1    <= 1'b0;
      hs_p1     <= ~SYNC_POL;
      vs_p1     <= ~SYNC_POL;
      vblank_p1 <= 1'b0;
    end else begin
      vld_p1    <= valid_p0;
      hs_p1     <= hsync_act_p0 ? SYNC_POL : ~SYNC_POL;
      vs_p1     <= vsync_act_p0 ? SYNC_POL : ~SYNC_POL;
      vblank_p1 <= vblank_p0;
    end
  end

  // ---- stage 1 -> stage 2 (pins) ----
  // Registered outputs; colour forced to black when blanked or disabled
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
      valid      <= 1'b0;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      vblank_irq <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      vga_r      <= (vld_p1 && ctrl_en) ? rd_data_p1.r : 8'h00;
      vga_g      <= (vld_p1 && ctrl_en) ? rd_data_p1.g : 8'h00;
      vga_b      <= (vld_p1 && ctrl_en) ? rd_data_p1.b : 8'h00;
      valid      <= vld_p1;
      hsync      <= hs_p1;
      vsync      <= vs_p1;
      vblank_irq <= vblank_p1;
      frame_cnt  <= frame_cnt + 16'(vblank_p1);
    end
  end

endmodule
